// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and saturate-mode encodings for the Gray counter.
// The helpers work on a fixed wide vector; callers zero-extend their WIDTH-bit
// value in and truncate the result back, which is exact for any WIDTH <= 64.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    // Values for the SATURATE parameter of gray_counter_n.
    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;

    // Binary to Gray: each bit is the XOR of itself and the next higher bit.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR prefix starting from the MSB. Zero-extended
    // upper bits keep the prefix at zero until the real MSB is reached.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational WIDTH-bit Gray-to-binary converter, usable standalone.
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Pure prefix-XOR conversion; no state.
    assign bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_counter_n.sv
// Registered Gray-code up/down counter with binary mirror, synchronous load,
// wrap/saturate limit handling and a one-cycle terminal-count pulse.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               SATURATE = SAT_WRAP,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary,
    output logic             tc,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RST_VAL)));

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_bin;

    // Load path converts the incoming Gray value so both registers agree.
    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (load_bin)
    );

    // Limit flag follows the direction input directly (not registered).
    assign at_limit = up ? (bin_q == MAX_VAL) : (bin_q == ZERO_VAL);

    // Modulo 2**WIDTH step; wrap at the limits falls out of the arithmetic.
    assign step_bin = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

    // Next-state mux: load beats count; idle holds value and clears tc.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        tc_d   = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_gray;
        end else if (en) begin
            if (at_limit) begin
                // Wrap mode takes the modulo step; saturate mode holds.
                tc_d = 1'b1;
                if (SATURATE != SAT_HOLD) begin
                    bin_d = step_bin;
                end
            end else begin
                bin_d = step_bin;
                if (SATURATE == SAT_HOLD) begin
                    tc_d = up ? (step_bin == MAX_VAL) : (step_bin == ZERO_VAL);
                end
            end
            gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
        end
    end

    // State registers with synchronous reset overriding load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign gray   = gray_q;
    assign binary = bin_q;
    assign tc     = tc_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: three instances share stimulus
// (wrap/reset-0, saturate, wrap with reset value 5); each task checks the
// instance its scenario is about.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_gray;
    logic [3:0] g0, b0, g1, b1, g2, b2;
    logic       tc0, tc1, tc2, al0, al1, al2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'd0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray(g0), .binary(b0), .tc(tc0), .at_limit(al0));

    gray_counter_n #(.WIDTH(4), .SATURATE(1), .RST_VAL(4'd0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray(g1), .binary(b1), .tc(tc1), .at_limit(al1));

    gray_counter_n #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'd5)) dut_rv5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray(g2), .binary(b2), .tc(tc2), .at_limit(al2));

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 4'b0000;
        tick(); tick();
        checks++; if (g0 !== 4'b0000) begin errors++; $display("FAIL reset_gray got=%b exp=0000", g0); end
        checks++; if (b0 !== 4'b0000) begin errors++; $display("FAIL reset_bin got=%b exp=0000", b0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc0); end
        checks++; if (g2 !== 4'b0111) begin errors++; $display("FAIL reset_rv5_gray got=%b exp=0111", g2); end
        checks++; if (b2 !== 4'b0101) begin errors++; $display("FAIL reset_rv5_bin got=%b exp=0101", b2); end
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_g [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                   4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                   4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic [3:0] prev_g;
        logic [3:0] exp_b;
        prev_g = g0;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_b = 4'(i + 1);
            checks++; if (g0 !== exp_g[i]) begin errors++; $display("FAIL up_gray step=%0d got=%b exp=%b", i, g0, exp_g[i]); end
            checks++; if (b0 !== exp_b) begin errors++; $display("FAIL up_bin step=%0d got=%b exp=%b", i, b0, exp_b); end
            checks++; if (tc0 !== (i == 15)) begin errors++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, tc0, (i == 15)); end
            checks++; if (al0 !== (exp_b == 4'b1111)) begin errors++; $display("FAIL up_at_limit step=%0d got=%b exp=%b", i, al0, (exp_b == 4'b1111)); end
            checks++; if ($countones(g0 ^ prev_g) != 1) begin errors++; $display("FAIL up_onebit step=%0d prev=%b now=%b", i, prev_g, g0); end
            prev_g = g0;
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; load_gray = 4'b1011; en = 1'b0;
        tick();
        checks++; if (g0 !== 4'b1011) begin errors++; $display("FAIL load_gray got=%b exp=1011", g0); end
        checks++; if (b0 !== 4'b1101) begin errors++; $display("FAIL load_bin got=%b exp=1101", b0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL load_tc got=%b exp=0", tc0); end
        en = 1'b1; up = 1'b1;
        tick();
        checks++; if (g0 !== 4'b1011) begin errors++; $display("FAIL load_en_gray got=%b exp=1011", g0); end
        checks++; if (b0 !== 4'b1101) begin errors++; $display("FAIL load_en_bin got=%b exp=1101", b0); end
        load = 1'b0; en = 1'b0;
        tick();
        checks++; if (b0 !== 4'b1101) begin errors++; $display("FAIL idle_hold_bin got=%b exp=1101", b0); end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_gray = 4'b0000; en = 1'b0;
        tick();
        load = 1'b0; up = 1'b0;
        #1;
        checks++; if (al0 !== 1'b1) begin errors++; $display("FAIL down_at_limit got=%b exp=1", al0); end
        en = 1'b1;
        tick();
        checks++; if (b0 !== 4'b1111) begin errors++; $display("FAIL down_wrap_bin got=%b exp=1111", b0); end
        checks++; if (g0 !== 4'b1000) begin errors++; $display("FAIL down_wrap_gray got=%b exp=1000", g0); end
        checks++; if (tc0 !== 1'b1) begin errors++; $display("FAIL down_wrap_tc got=%b exp=1", tc0); end
        tick();
        checks++; if (b0 !== 4'b1110) begin errors++; $display("FAIL down_next_bin got=%b exp=1110", b0); end
        checks++; if (g0 !== 4'b1001) begin errors++; $display("FAIL down_next_gray got=%b exp=1001", g0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL down_next_tc got=%b exp=0", tc0); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_gray = 4'b1001; en = 1'b0;
        tick();
        checks++; if (b1 !== 4'b1110) begin errors++; $display("FAIL sat_load_bin got=%b exp=1110", b1); end
        checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL sat_load_tc got=%b exp=0", tc1); end
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b1 !== 4'b1111) begin errors++; $display("FAIL sat_up_bin step=%0d got=%b exp=1111", i, b1); end
            checks++; if (g1 !== 4'b1000) begin errors++; $display("FAIL sat_up_gray step=%0d got=%b exp=1000", i, g1); end
            checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL sat_up_tc step=%0d got=%b exp=1", i, tc1); end
            checks++; if (al1 !== 1'b1) begin errors++; $display("FAIL sat_up_at_limit step=%0d got=%b exp=1", i, al1); end
        end
        load = 1'b1; load_gray = 4'b0001; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (b1 !== 4'b0000) begin errors++; $display("FAIL sat_dn_bin step=%0d got=%b exp=0000", i, b1); end
            checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL sat_dn_tc step=%0d got=%b exp=1", i, tc1); end
        end
        en = 1'b0;
        tick();
        checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL sat_idle_tc got=%b exp=0", tc1); end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_gray = 4'b1111; en = 1'b0;
        tick();
        checks++; if (b2 !== 4'b1010) begin errors++; $display("FAIL rmid_load_bin got=%b exp=1010", b2); end
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++; if (b2 !== 4'b1011) begin errors++; $display("FAIL rmid_step_bin got=%b exp=1011", b2); end
        rst = 1'b1; load = 1'b1; load_gray = 4'b0000;
        tick();
        checks++; if (b2 !== 4'b0101) begin errors++; $display("FAIL rmid_rst_bin got=%b exp=0101", b2); end
        checks++; if (g2 !== 4'b0111) begin errors++; $display("FAIL rmid_rst_gray got=%b exp=0111", g2); end
        checks++; if (tc2 !== 1'b0) begin errors++; $display("FAIL rmid_rst_tc got=%b exp=0", tc2); end
        rst = 1'b0; load = 1'b0;
        tick();
        checks++; if (b2 !== 4'b0110) begin errors++; $display("FAIL rmid_resume_bin got=%b exp=0110", b2); end
        checks++; if (g2 !== 4'b0101) begin errors++; $display("FAIL rmid_resume_gray got=%b exp=0101", g2); end
        en = 1'b0;
    endtask

    task automatic test_dir_toggle();
        logic [3:0] exp_b [4] = '{4'b0100, 4'b0011, 4'b0100, 4'b0011};
        logic [3:0] exp_g [4] = '{4'b0110, 4'b0010, 4'b0110, 4'b0010};
        load = 1'b1; load_gray = 4'b0010; en = 1'b0;
        tick();
        checks++; if (b0 !== 4'b0011) begin errors++; $display("FAIL dir_load_bin got=%b exp=0011", b0); end
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            tick();
            checks++; if (b0 !== exp_b[i]) begin errors++; $display("FAIL dir_bin step=%0d got=%b exp=%b", i, b0, exp_b[i]); end
            checks++; if (g0 !== exp_g[i]) begin errors++; $display("FAIL dir_gray step=%0d got=%b exp=%b", i, g0, exp_g[i]); end
            checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL dir_tc step=%0d got=%b exp=0", i, tc0); end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load();
        test_down_wrap();
        test_saturate();
        test_reset_mid();
        test_dir_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
